// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter fetch sequencer.
package pc_pkg;

    localparam int                  PC_WIDTH      = 6;
    localparam logic [PC_WIDTH-1:0] RESET_PC      = '0;
    localparam int                  FETCH_TIMEOUT = 16;
    localparam int                  FETCH_CNT_W   = 8;
    localparam int                  TIMER_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_UPDATE = 3'd2,
        ST_HALT   = 3'd3,
        ST_ERR    = 3'd4
    } fetch_state_e;

    function automatic logic [FETCH_CNT_W-1:0] sat_inc(input logic [FETCH_CNT_W-1:0] v);
        return (&v) ? v : v + FETCH_CNT_W'(1);
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// Clear/enable up-counter with a terminal-count flag against a loadable compare value.
module fetch_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] tc_val_i,
    output logic [W-1:0] count_o,
    output logic         tc_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear has priority so a restart in the same cycle never counts.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == tc_val_i);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and instruction-fetch handshake sequencer with halt, stall and timeout handling.
module pc_fetch_ctrl #(
    parameter int               WIDTH    = pc_pkg::PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(pc_pkg::RESET_PC),
    parameter int               TIMEOUT  = pc_pkg::FETCH_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             halt_req,
    input  logic             err_clr,
    input  logic             stall,
    input  logic [WIDTH-1:0] next_pc,
    input  logic             imem_ack,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_inc,
    output logic             imem_req,
    output logic             instr_valid,
    output logic             halted,
    output logic             err,
    output logic [7:0]       fetch_count
);

    import pc_pkg::*;

    fetch_state_e           state_q, state_d;
    logic [WIDTH-1:0]       pc_q, pc_d;
    logic [FETCH_CNT_W-1:0] cnt_q, cnt_d;
    logic                   halt_q, halt_d;
    logic                   iv_q, iv_d;

    logic                   tmr_clr;
    logic                   tmr_en;
    logic                   tmr_tc;
    logic [TIMER_W-1:0]     tmr_count;

    fetch_timer #(
        .W (TIMER_W)
    ) u_req_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .tc_val_i (TIMER_W'(TIMEOUT - 1)),
        .count_o  (tmr_count),
        .tc_o     (tmr_tc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        halt_d  = halt_q | halt_req;
        iv_d    = (state_q == ST_REQ) && imem_ack;

        case (state_q)
            ST_IDLE: begin
                if (halt_q) begin
                    state_d = ST_HALT;
                end else if (run) begin
                    state_d = ST_REQ;
                    tmr_clr = 1'b1;
                end
            end
            ST_REQ: begin
                tmr_en = 1'b1;
                // An ack in the terminal cycle still completes the fetch.
                if (imem_ack) begin
                    state_d = ST_UPDATE;
                end else if (tmr_tc) begin
                    state_d = ST_ERR;
                end
            end
            ST_UPDATE: begin
                if (!stall) begin
                    pc_d  = next_pc;
                    cnt_d = sat_inc(cnt_q);
                    if (halt_q) begin
                        state_d = ST_HALT;
                    end else if (run) begin
                        state_d = ST_REQ;
                        tmr_clr = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            ST_ERR: begin
                if (err_clr) begin
                    state_d = ST_IDLE;
                    tmr_clr = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            halt_q  <= 1'b0;
            iv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            halt_q  <= halt_d;
            iv_q    <= iv_d;
        end
    end

    assign pc          = pc_q;
    assign pc_inc      = pc_q + WIDTH'(1);
    assign imem_req    = (state_q == ST_REQ);
    assign instr_valid = iv_q;
    assign halted      = (state_q == ST_HALT);
    assign err         = (state_q == ST_ERR);
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl; external 2:1 next-PC mux modelled here.
module tb_pc_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run, halt_req, err_clr, stall, imem_ack;
    logic [5:0] next_pc, pc, pc_inc;
    logic       imem_req, instr_valid, halted, err;
    logic [7:0] fetch_count;

    logic       use_ext;
    logic [5:0] ext_pc;

    int         n_chk  = 0;
    int         n_pass = 0;

    logic [5:0] exp_pc;
    logic [7:0] exp_cnt;
    logic [13:0] sb_q[$];

    always #5 clk = ~clk;

    assign next_pc = use_ext ? ext_pc : pc_inc;

    pc_fetch_ctrl #(
        .WIDTH    (6),
        .RESET_PC (6'd0),
        .TIMEOUT  (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .halt_req    (halt_req),
        .err_clr     (err_clr),
        .stall       (stall),
        .next_pc     (next_pc),
        .imem_ack    (imem_ack),
        .pc          (pc),
        .pc_inc      (pc_inc),
        .imem_req    (imem_req),
        .instr_valid (instr_valid),
        .halted      (halted),
        .err         (err),
        .fetch_count (fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc"}, pc, 6'd0);
        chk({tag, "_req"}, imem_req, 1'b0);
        chk({tag, "_iv"}, instr_valid, 1'b0);
        chk({tag, "_halted"}, halted, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_cnt"}, fetch_count, 8'd0);
    endtask

    // Caller is positioned just after an edge with the DUT in REQ.
    task automatic fetch(input int waitc, input int stallc);
        logic [5:0]  npc;
        logic [7:0]  ncnt;
        logic [13:0] item;
        chk("req_on", imem_req, 1'b1);
        repeat (waitc) step();
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        chk("iv_pulse", instr_valid, 1'b1);
        chk("pc_hold_upd", pc, exp_pc);
        chk("err_off", err, 1'b0);
        npc  = use_ext ? ext_pc : exp_pc + 6'd1;
        ncnt = (exp_cnt == 8'd255) ? 8'd255 : exp_cnt + 8'd1;
        sb_q.push_back({ncnt, npc});
        stall = (stallc > 0);
        for (int i = 0; i < stallc; i++) begin
            step();
            chk("stall_pc", pc, exp_pc);
            chk("stall_iv", instr_valid, 1'b0);
            if (i == stallc - 1) stall = 1'b0;
        end
        step();
        item = sb_q.pop_front();
        chk("upd_pc", pc, item[5:0]);
        chk("upd_cnt", fetch_count, item[13:6]);
        chk("iv_single", instr_valid, 1'b0);
        exp_pc  = item[5:0];
        exp_cnt = item[13:6];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; run = 1'b1; halt_req = 1'b0; err_clr = 1'b0;
        stall = 1'b0; imem_ack = 1'b0; use_ext = 1'b0; ext_pc = 6'd0;
        exp_pc = 6'd0; exp_cnt = 8'd0;

        // Reset with run held high
        step(); step();
        chk_reset_outputs("rst");
        chk("rst_pcinc", pc_inc, 6'd1);
        rst_n = 1'b1;
        step();
        chk("first_req", imem_req, 1'b1);

        // Three sequential fetches, pc_inc fed back
        for (int k = 0; k < 3; k++) fetch(0, 0);
        chk("three_pc", pc, 6'd3);
        chk("three_cnt", fetch_count, 8'd3);

        // Wrap
        use_ext = 1'b1; ext_pc = 6'd62;
        fetch(0, 0);
        use_ext = 1'b0;
        fetch(0, 0);
        chk("wrap_pc63", pc, 6'd63);
        chk("wrap_inc0", pc_inc, 6'd0);
        fetch(0, 0);
        chk("wrap_pc0", pc, 6'd0);

        // Stall with external target
        use_ext = 1'b1; ext_pc = 6'd40;
        fetch(1, 3);
        use_ext = 1'b0;
        chk("stall_pc40", pc, 6'd40);

        // Ack in the 16th REQ cycle still completes
        fetch(15, 0);
        chk("late_ack_err", err, 1'b0);

        // No ack: error after 16 REQ cycles
        repeat (15) step();
        chk("to_req15", imem_req, 1'b1);
        chk("to_err15", err, 1'b0);
        step();
        chk("to_err", err, 1'b1);
        chk("to_req_off", imem_req, 1'b0);
        chk("to_pc", pc, exp_pc);
        run = 1'b0;
        step();
        chk("err_sticky", err, 1'b1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_err", err, 1'b0);
        chk("clr_req", imem_req, 1'b0);
        chk("clr_pc", pc, exp_pc);
        run = 1'b1;
        step();
        chk("clr_restart", imem_req, 1'b1);

        // Halt pulsed mid-REQ
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        fetch(0, 0);
        chk("halt_on", halted, 1'b1);
        chk("halt_req_off", imem_req, 1'b0);
        repeat (4) step();
        chk("halt_stays", halted, 1'b1);
        chk("halt_noreq", imem_req, 1'b0);
        chk("halt_pc", pc, exp_pc);

        // Async reset mid-REQ
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        chk("ar_req", imem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        step();
        rst_n = 1'b1;
        exp_pc = 6'd0; exp_cnt = 8'd0;
        step();
        chk("ar_nohalt", halted, 1'b0);
        chk("ar_req2", imem_req, 1'b1);

        // Saturating fetch counter
        for (int k = 0; k < 257; k++) fetch(0, 0);
        chk("sat_cnt", fetch_count, 8'd255);
        chk("sat_pc", pc, 6'(257 % 64));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter register and fetch sequencer for the small program counter design. It holds the current 6-bit PC and presents `pc` and `pc_inc` to the next-PC select stage. The 2:1 next-PC mux feeds its 6-bit result back on `next_pc`. The block handshakes each fetch with instruction memory, loads `next_pc` once a fetch completes, and flags stalled, halted and timed-out conditions.

## Interface
- `WIDTH`, 6: PC width in bits.
- `RESET_PC`, 6'd0: PC value loaded on reset.
- `TIMEOUT`, 16: max REQ cycles without `imem_ack` before error; legal range 2..255.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset is asynchronous and active-low.
- `run` in 1: level enable; starts and continues fetching.
- `halt_req` in 1: halt request; latched until honored.
- `err_clr` in 1: clears sticky error and returns to IDLE.
- `stall` in 1: holds PC update while high.
- `next_pc` in WIDTH: next-PC value from the select mux.
- `imem_ack` in 1: instruction memory completes current fetch.
- `pc` out WIDTH: current PC (registered).
- `pc_inc` out WIDTH: `pc + 1` mod 2^WIDTH (combinational from `pc`); drives the mux d0 input.
- `imem_req` out 1: fetch request for address `pc`.
- `instr_valid` out 1: one-cycle pulse, fetched word valid.
- `halted` out 1: in HALT state.
- `err` out 1: sticky fetch timeout.
- `fetch_count` out 8: completed PC updates, saturating at 255.

## Operation
- States: IDLE, REQ, UPDATE, HALT, ERR. Encoding is 3-bit binary.
- **IDLE:** `imem_req` is 0.
  - If the halt latch is set, go to HALT.
  - Else if `run`=1, go to REQ.
- **REQ:** `imem_req` is 1 and `pc` is held. The timer increments every REQ cycle.
  - If `imem_ack`=1, go to UPDATE.
  - Else if the timer equals TIMEOUT-1, go to ERR.
  - Ack wins over timeout in the same cycle.
  - `run` falling during REQ does not abort; the fetch completes.
- **UPDATE:** `instr_valid`=1 on the first UPDATE cycle only.
  - While `stall`=1, remain in UPDATE with `pc` held.
  - On the first cycle with `stall`=0: `pc` <= `next_pc`, and `fetch_count` increments, saturating at 255. Then:
    - halt latch set: go to HALT;
    - else `run`=1: go to REQ;
    - else: go to IDLE.
- **HALT:** `halted`=1 and `imem_req`=0. `pc` is frozen. Exit only by reset.
- **ERR:** `err`=1 and `imem_req`=0. `pc` is frozen.
  - `err_clr`=1 goes to IDLE and clears `err` and the timer.
  - `halt_req` in ERR is latched but honored only after `err_clr`.
- **Halt latch:** set by `halt_req`=1 in any state; cleared only by reset.
- **Wrap:** PC arithmetic is unsigned WIDTH bits. `pc_inc` at 63 is 0. `next_pc` is loaded verbatim, with no range check.
- **Timer:** clears on entry to REQ.
- **Reset** (asynchronous, any state, including mid-REQ), all outputs deassert immediately:
  - state = IDLE, `pc` = RESET_PC;
  - `imem_req` = `instr_valid` = `halted` = `err` = 0;
  - `fetch_count` = 0, timer = 0, halt latch = 0.

## Timing
- **First request:** `run` high at edge E0 gives `imem_req`=1 from E0+1.
- **Fetch completion, ack sampled high at edge N:**
  - `instr_valid` is high during cycle N..N+1.
  - With `stall`=0, the new `pc` is visible after edge N+1.
  - `imem_req` re-asserts after edge N+1 if `run`=1.
- **Minimum fetch period:** 2 cycles per instruction with zero-wait memory.
- `next_pc` is sampled only at the updating edge. It must be stable for that edge, which is a combinational path from `pc_inc` through the mux.
- **Timeout:** ERR is entered TIMEOUT cycles after REQ entry when no ack arrives.

## Structure
- **Shared package `pc_pkg`:**
  - state enum/localparams;
  - `PC_WIDTH`=6, `RESET_PC`, `FETCH_TIMEOUT`;
  - `FETCH_CNT_W`=8.
- **Sub-module `fetch_timer`:** loadable clear/enable counter with a terminal-count output.
  - Instantiated once for the REQ timeout.
  - Reusable for future wait-state counting.
- The existing 2:1 next-PC mux stays outside this block; top level wires `pc_inc` to d0 and the mux output to `next_pc`.

## Test plan
- **Reset and first fetch:** reset with `run`=1, ack 1 cycle after req, `next_pc`=`pc_inc`.
  - `pc` steps 0,1,2,3 every 2 cycles.
  - `instr_valid` pulses once per step.
  - `fetch_count`=3 after three updates.
- **Wrap:** preload 62 via `next_pc`, then increment.
  - `pc` goes 62, 63, 0.
  - `pc_inc` reads 0 while `pc`=63.
- **Stall:** `stall`=1 for 3 cycles during UPDATE with `next_pc`=6'd40.
  - `pc` is held.
  - `instr_valid` is a single pulse.
  - `pc`=40 one edge after `stall` drops.
- **Timeout then clear:** TIMEOUT=16, no ack.
  - `err`=1 and `imem_req`=0 after 16 REQ cycles.
  - Ack on cycle 16 instead gives no error.
  - `err_clr` returns to IDLE with `pc` unchanged.
- **Halt:** `halt_req` pulsed mid-REQ.
  - The fetch completes, `pc` updates, then `halted`=1 permanently.
  - `imem_req` stays 0 despite `run`=1.
- **Async reset mid-REQ:** drop `rst_n` between edges.
  - All outputs reach reset values before the next edge; `pc`=RESET_PC.
